// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM state type,
// lane widths and the alignment rule.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE_RD,
        ST_STORE_WR
    } lsu_state_e;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    function automatic logic is_aligned(lsu_op_e op, logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:         return (lo == 2'b00);
            OP_LH, OP_LHU, OP_SH: return !lo[0];
            default:              return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extract + sign/zero extend for loads, and
// read-modify-write merge of a half/byte into the current RAM word for stores.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  lsu_op_e           op,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] ram_word,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merge_data
);

    logic [BYTE_W-1:0] lane_b;
    logic [HALF_W-1:0] lane_h;

    always_comb begin
        lane_b     = ram_word[{addr_lo, 3'b000} +: BYTE_W];
        lane_h     = addr_lo[1] ? ram_word[31:16] : ram_word[15:0];
        load_data  = ram_word;
        merge_data = wdata;
        case (op)
            OP_LH:  load_data = {{(WORD_W-HALF_W){lane_h[HALF_W-1]}}, lane_h};
            OP_LHU: load_data = {{(WORD_W-HALF_W){1'b0}}, lane_h};
            OP_LB:  load_data = {{(WORD_W-BYTE_W){lane_b[BYTE_W-1]}}, lane_b};
            OP_LBU: load_data = {{(WORD_W-BYTE_W){1'b0}}, lane_b};
            OP_SH: begin
                merge_data = ram_word;
                merge_data[{addr_lo[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
            end
            OP_SB: begin
                merge_data = ram_word;
                merge_data[{addr_lo, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a word-only data RAM.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned requests with misalign_err.
//
// state       | meaning
// ------------+-------------------------------------------------
// ST_IDLE     | ready for a request, no RAM access
// ST_LOAD     | RAM read; lane extracted into rdata at the edge
// ST_STORE_RD | RAM read of the word being partially overwritten
// ST_STORE_WR | RAM write of the merged (or full SW) word
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              store_done,
    output logic              misalign_err,
    output logic [31:0]       ram_address,
    output logic [DATA_W-1:0] ram_data_write,
    output logic              ram_write_en,
    output logic              ram_read_en,
    input  logic [DATA_W-1:0] ram_data_in
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    lsu_state_e        state;
    lsu_op_e           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merge_q;
    logic [ADDR_W-1:0] addr_word;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_data;
    lsu_op_e           req_op_e;
    logic              req_aligned;
    logic              reject;

    assign req_op_e    = lsu_op_e'(req_op);
    assign req_aligned = is_aligned(req_op_e, req_addr[1:0]);
    assign reject      = TRAP_EN && !req_aligned;

    assign req_ready      = (state == ST_IDLE);
    assign addr_word      = {addr_q[ADDR_W-1:2], 2'b00};
    assign ram_address    = 32'(addr_word);
    assign ram_data_write = merge_q;

    lsu_byte_lane u_lane (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .ram_word   (ram_data_in),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            op_q         <= OP_LW;
            addr_q       <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
            rdata        <= '0;
            rdata_valid  <= 1'b0;
            store_done   <= 1'b0;
            ram_read_en  <= 1'b0;
            ram_write_en <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            store_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && !reject) begin
                        op_q    <= req_op_e;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        case (req_op_e)
                            OP_SW: begin
                                // SW skips the read; the merge register carries the full word
                                merge_q      <= req_wdata;
                                ram_write_en <= 1'b1;
                                state        <= ST_STORE_WR;
                            end
                            OP_SH, OP_SB: begin
                                ram_read_en <= 1'b1;
                                state       <= ST_STORE_RD;
                            end
                            default: begin
                                ram_read_en <= 1'b1;
                                state       <= ST_LOAD;
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    rdata       <= load_data;
                    rdata_valid <= 1'b1;
                    ram_read_en <= 1'b0;
                    state       <= ST_IDLE;
                end
                ST_STORE_RD: begin
                    merge_q      <= merge_data;
                    ram_read_en  <= 1'b0;
                    ram_write_en <= 1'b1;
                    state        <= ST_STORE_WR;
                end
                ST_STORE_WR: begin
                    ram_write_en <= 1'b0;
                    store_done   <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: begin
                    ram_read_en  <= 1'b0;
                    ram_write_en <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) misalign_err <= 1'b0;
        else       misalign_err <= (state == ST_IDLE) && req_valid && reject;
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected RAM/response
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_load_store_unit;

    localparam int K_READ  = 0;
    localparam int K_WRITE = 1;
    localparam int K_LOAD  = 2;
    localparam int K_DONE  = 3;
    localparam int K_MIS   = 4;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        store_done;
    logic        misalign_err;
    logic [31:0] ram_address;
    logic [31:0] ram_data_write;
    logic        ram_write_en;
    logic        ram_read_en;
    logic [31:0] ram_data_in;

    logic [31:0] mem [0:63];
    ev_t         sb [$];
    int          total = 0;
    int          bad   = 0;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rdata          (rdata),
        .rdata_valid    (rdata_valid),
        .store_done     (store_done),
        .misalign_err   (misalign_err),
        .ram_address    (ram_address),
        .ram_data_write (ram_data_write),
        .ram_write_en   (ram_write_en),
        .ram_read_en    (ram_read_en),
        .ram_data_in    (ram_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_data_in = mem[ram_address[7:2]];
    always @(posedge clk) if (ram_write_en) mem[ram_address[7:2]] <= ram_data_write;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind; e.a = a; e.d = d;
        sb.push_back(e);
    endtask

    task automatic match(input string name, input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected event addr=%h data=%h, nothing expected", name, a, d);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.a !== a || e.d !== d) begin
                bad++;
                $display("FAIL %s: got kind=%0d addr=%h data=%h want kind=%0d addr=%h data=%h",
                         name, kind, a, d, e.kind, e.a, e.d);
            end
        end
    endtask

    // monitor: one RAM access / pulse per cycle, compared in arrival order
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ram_read_en || ram_write_en) begin
                    total++;
                    if (ram_read_en && ram_write_en) begin
                        bad++;
                        $display("FAIL ram_en_exclusive: got read=1 write=1 want at most one");
                    end
                end
                if (ram_read_en)  match("ram_read",  K_READ,  ram_address, 32'h0);
                if (ram_write_en) match("ram_write", K_WRITE, ram_address, ram_data_write);
                if (rdata_valid)  match("load_rdata", K_LOAD, 32'h0, rdata);
                if (store_done)   match("store_done", K_DONE, 32'h0, 32'h0);
                if (misalign_err) match("misalign",   K_MIS,  32'h0, 32'h0);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input bit hold, output int waits);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        waits = 0;
        while (!req_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: got req_ready=0 want 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        mem[0] <= 32'h8001_0000;
        mem[1] <= 32'hCAFE_F00D;
        mem[2] <= 32'h0000_80F0;
        mem[3] <= 32'h1122_3344;
        mem[8] <= 32'h5555_AAAA;
        reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        #23;
        check("rst_rdata",        rdata,        32'h0);
        check("rst_rdata_valid",  {31'b0, rdata_valid},  32'h0);
        check("rst_store_done",   {31'b0, store_done},   32'h0);
        check("rst_misalign_err", {31'b0, misalign_err}, 32'h0);
        check("rst_ram_write_en", {31'b0, ram_write_en}, 32'h0);
        check("rst_ram_read_en",  {31'b0, ram_read_en},  32'h0);
        check("rst_req_ready",    {31'b0, req_ready},    32'h1);
        @(negedge clk); reset = 1'b0;
        idle(2);

        // byte loads: sign and zero extension
        push(K_READ, 32'h8, 0); push(K_LOAD, 0, 32'hFFFF_FFF0);
        issue(3'd3, 32'h8, 0, 0, w);
        push(K_READ, 32'h8, 0); push(K_LOAD, 0, 32'h0000_0080);
        issue(3'd4, 32'h9, 0, 0, w);
        idle(3);

        // LH with explicit latency check: accept edge N, valid after edge N+1
        push(K_READ, 32'h0, 0); push(K_LOAD, 0, 32'hFFFF_8001);
        issue(3'd1, 32'h2, 0, 0, w);
        @(negedge clk);
        check("lh_valid_early", {31'b0, rdata_valid}, 32'h0);
        check("lh_read_en",     {31'b0, ram_read_en}, 32'h1);
        @(negedge clk);
        check("lh_valid_n2", {31'b0, rdata_valid}, 32'h1);
        check("lh_rdata",    rdata, 32'hFFFF_8001);
        push(K_READ, 32'h0, 0); push(K_LOAD, 0, 32'h0000_8001);
        issue(3'd2, 32'h2, 0, 0, w);
        idle(3);
        check("rdata_hold", rdata, 32'h0000_8001);

        // SB read-modify-write, then SH into the upper half, then read back
        push(K_READ, 32'hC, 0); push(K_WRITE, 32'hC, 32'h1122_AB44); push(K_DONE, 0, 0);
        issue(3'd7, 32'hD, 32'h0000_00AB, 0, w);
        idle(4);
        push(K_READ, 32'hC, 0); push(K_WRITE, 32'hC, 32'hBEEF_AB44); push(K_DONE, 0, 0);
        issue(3'd6, 32'hE, 32'h0000_BEEF, 0, w);
        idle(4);
        push(K_READ, 32'hC, 0); push(K_LOAD, 0, 32'hBEEF_AB44);
        issue(3'd0, 32'hC, 0, 0, w);
        push(K_READ, 32'hC, 0); push(K_LOAD, 0, 32'hFFFF_FFBE);
        issue(3'd3, 32'hF, 0, 0, w);
        idle(3);

        // misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
        push(K_MIS, 0, 0);
`else
        push(K_READ, 32'h4, 0); push(K_LOAD, 0, 32'hCAFE_F00D);
`endif
        issue(3'd0, 32'h6, 0, 0, w);
        idle(4);

        // back-to-back SW then LW with req_valid held
        push(K_WRITE, 32'h10, 32'hDEAD_BEEF); push(K_DONE, 0, 0);
        push(K_READ, 32'h10, 0); push(K_LOAD, 0, 32'hDEAD_BEEF);
        issue(3'd5, 32'h10, 32'hDEAD_BEEF, 1, w);
        issue(3'd0, 32'h10, 0, 0, w);
        check("b2b_wait_cycles", 32'(w), 32'd1);
        idle(4);

        // reset in the middle of an SH read-modify-write: no write may follow
        issue(3'd6, 32'h20, 32'h0000_1234, 0, w);
        #1 reset = 1'b1;
        #1;
        check("midrst_write_en",  {31'b0, ram_write_en}, 32'h0);
        check("midrst_read_en",   {31'b0, ram_read_en},  32'h0);
        check("midrst_rdata",     rdata, 32'h0);
        check("midrst_store_done", {31'b0, store_done},  32'h0);
        idle(2);
        reset = 1'b0;
        idle(3);
        check("midrst_req_ready", {31'b0, req_ready}, 32'h1);
        check("midrst_mem_intact", mem[8], 32'h5555_AAAA);

        idle(2);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning word width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, meaning the CPU memory request is present.
REQ-006 SHALL have port req_ready, output, 1, meaning the unit accepts the request this cycle.
REQ-007 SHALL have port req_op, input, 3, meaning LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
REQ-008 SHALL have port req_addr, input, ADDR_W, meaning the byte address.
REQ-009 SHALL have port req_wdata, input, 32, meaning store data, right-justified for SH/SB.
REQ-010 SHALL have port rdata, output, 32, meaning the extended load result.
REQ-011 SHALL have port rdata_valid, output, 1, meaning a one-cycle pulse when rdata is updated.
REQ-012 SHALL have port store_done, output, 1, meaning a one-cycle pulse when a store's RAM write is issued.
REQ-013 SHALL have port misalign_err, output, 1, meaning a one-cycle pulse for a rejected misaligned request.
REQ-014 SHALL have ports ram_address (output, 32), ram_data_write (output, 32), ram_write_en (output, 1), ram_read_en (output, 1) and ram_data_in (input, 32), meaning the word-only data-RAM port: combinational read, write on posedge, internal addr>>2.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, STORE_RD and STORE_WR; req_ready=1 only in IDLE.
REQ-016 SHALL, in IDLE on req_valid with an aligned address, latch op, addr and wdata and go to LOAD (loads), STORE_WR (SW) or STORE_RD (SH/SB).
REQ-017 SHALL treat alignment as: word needs addr[1:0]=0, half needs addr[0]=0, byte always aligned.
REQ-018 SHALL drive ram_address as the latched addr with bits [1:0] forced to 0 in every non-IDLE state.
REQ-019 SHALL, in LOAD: ram_read_en=1; at the edge register the extracted lane (byte k = bits [8k+7:8k], little-endian) into rdata, sign-extended for LH/LB and zero-extended for LHU/LBU; pulse rdata_valid; go to IDLE.
REQ-020 SHALL give load latency as: accept at edge N, rdata_valid high in the cycle after edge N+1.
REQ-021 SHALL, in STORE_RD: ram_read_en=1; register ram_data_in merged with the new lane(s) into the merge register; go to STORE_WR.
REQ-022 SHALL, in STORE_WR: ram_write_en=1, ram_data_write=merge register (or latched wdata for SW); pulse store_done on leaving; go to IDLE.
REQ-023 SHALL give store costs as 1 cycle after accept for SW and 2 for SH/SB.
REQ-024 SHALL never assert ram_write_en and ram_read_en together; both are 0 in IDLE.
REQ-025 SHALL ignore req_valid outside IDLE; the requester holds the request until req_ready.
REQ-026 SHALL hold rdata until the next load completes.

Reset
REQ-027 SHALL, on reset assertion at any time, force state to IDLE and rdata, rdata_valid, store_done, misalign_err, ram_write_en and ram_read_en to 0, asynchronously.
REQ-028 SHALL abandon an in-progress store on reset mid-RMW, with no RAM write issued.

Configuration
REQ-029 SHALL, with LSU_MISALIGN_TRAP_EN defined, reject a misaligned request: pulse misalign_err the next cycle, stay in IDLE, no RAM access.
REQ-030 SHALL, without LSU_MISALIGN_TRAP_EN, accept a misaligned request with low address bits truncated to alignment; misalign_err is tied to 0.

Structure
REQ-031 SHALL place op encodings, the FSM state type and lane-width constants in shared package lsu_pkg.
REQ-032 SHALL implement lane extract/extend and store merge in combinational sub-module lsu_byte_lane.

Verification
REQ-033 SHALL cover: RAM word 0x8 = 0x000080F0; LB addr 0x8 -> rdata=0xFFFFFFF0; LBU addr 0x9 -> 0x00000080.
REQ-034 SHALL cover: SB addr 0x0D data 0xAB over word 0x11223344 -> one read then one write of 0x1122AB44; store_done pulses once.
REQ-035 SHALL cover: LH addr 0x2 over 0x8001_0000 -> rdata=0xFFFF8001; LHU -> 0x00008001; rdata_valid at the accept edge +2.
REQ-036 SHALL cover: with LSU_MISALIGN_TRAP_EN, LW addr 0x6 -> misalign_err pulse, no ram_read_en/ram_write_en; without it -> word 0x4 read.
REQ-037 SHALL cover: reset asserted during STORE_RD of SH -> no ram_write_en ever, outputs 0, req_ready=1 after release.
REQ-038 SHALL cover: back-to-back SW 0x10 then LW 0x10 with req_valid held -> second accepted only when req_ready=1, rdata equals stored data.
